// File: rtl/fft_in_loader.sv
`default_nettype none
// ============================================================================
// Module   : fft_in_loader
// Purpose  : Serial-to-parallel 8-sample frame loader feeding the first FFT
//            butterfly stage in bit-reversed order, with resync and drop flag.
// Revision : 1.0
// ============================================================================
module fft_in_loader #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         in_sof,
    input  logic         in_inv,
    input  logic         clr_err,
    output logic [W-1:0] out_x0,
    output logic [W-1:0] out_x1,
    output logic [W-1:0] out_x2,
    output logic [W-1:0] out_x3,
    output logic [W-1:0] out_x4,
    output logic [W-1:0] out_x5,
    output logic [W-1:0] out_x6,
    output logic [W-1:0] out_x7,
    output logic         out_en,
    output logic         out_inv,
    output logic [7:0]   frame_cnt,
    output logic         drop_err
);

    logic [2:0]   r_wr_idx;
    logic         r_mode;
    logic         r_out_en;
    logic         r_out_inv;
    logic [7:0]   r_frame_cnt;
    logic         r_drop_err;
    logic [W-1:0] r_st  [0:6];
    logic [W-1:0] r_out [0:7];
    logic [W-1:0] w_sample [0:7];

    logic w_take_s0;
    logic w_done;
    logic w_store_mid;
    logic w_drop;

    // An explicit start-of-frame always wins, even when it truncates a frame.
    assign w_take_s0   = in_valid && (in_sof || (r_wr_idx == 3'd0));
    assign w_done      = in_valid && !in_sof && (r_wr_idx == 3'd7);
    assign w_store_mid = in_valid && !w_take_s0 && !w_done;
    assign w_drop      = in_valid && in_sof && (r_wr_idx != 3'd0);

    generate
        for (genvar i = 0; i < 7; i++) begin : g_st
            logic w_we;
            if (i == 0) begin : g_s0
                assign w_we = w_take_s0;
            end else begin : g_sn
                assign w_we = w_store_mid && (r_wr_idx == 3'(i));
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_st[i] <= '0;
                end else if (w_we) begin
                    r_st[i] <= in_data;
                end
            end

            assign w_sample[i] = r_st[i];
        end
    endgenerate

    // s7 is never staged: it goes straight from the input into the output bank.
    assign w_sample[7] = in_data;

    generate
        for (genvar k = 0; k < 8; k++) begin : g_out
            localparam int c_src = ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_out[k] <= '0;
                end else if (w_done) begin
                    r_out[k] <= w_sample[c_src];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_idx    <= 3'd0;
            r_mode      <= 1'b0;
            r_out_en    <= 1'b0;
            r_out_inv   <= 1'b0;
            r_frame_cnt <= 8'd0;
            r_drop_err  <= 1'b0;
        end else begin
            r_out_en <= w_done;
            if (w_take_s0) begin
                r_wr_idx <= 3'd1;
                r_mode   <= in_inv;
            end else if (w_done) begin
                r_wr_idx    <= 3'd0;
                r_out_inv   <= r_mode;
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end else if (w_store_mid) begin
                r_wr_idx <= r_wr_idx + 3'd1;
            end

            if (w_drop) begin
                r_drop_err <= 1'b1;
            end else if (clr_err) begin
                r_drop_err <= 1'b0;
            end
        end
    end

    assign out_x0    = r_out[0];
    assign out_x1    = r_out[1];
    assign out_x2    = r_out[2];
    assign out_x3    = r_out[3];
    assign out_x4    = r_out[4];
    assign out_x5    = r_out[5];
    assign out_x6    = r_out[6];
    assign out_x7    = r_out[7];
    assign out_en    = r_out_en;
    assign out_inv   = r_out_inv;
    assign frame_cnt = r_frame_cnt;
    assign drop_err  = r_drop_err;

endmodule
`default_nettype wire

// File: tb/tb_fft_in_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_in_loader
// Purpose  : Directed, table-driven self-checking bench for fft_in_loader.
// Revision : 1.0
// ============================================================================
module tb_fft_in_loader;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_sof;
    logic        in_inv;
    logic        clr_err;
    logic [15:0] out_x0, out_x1, out_x2, out_x3, out_x4, out_x5, out_x6, out_x7;
    logic        out_en;
    logic        out_inv;
    logic [7:0]  frame_cnt;
    logic        drop_err;

    fft_in_loader #(.W(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_sof   (in_sof),
        .in_inv   (in_inv),
        .clr_err  (clr_err),
        .out_x0   (out_x0),
        .out_x1   (out_x1),
        .out_x2   (out_x2),
        .out_x3   (out_x3),
        .out_x4   (out_x4),
        .out_x5   (out_x5),
        .out_x6   (out_x6),
        .out_x7   (out_x7),
        .out_en   (out_en),
        .out_inv  (out_inv),
        .frame_cnt(frame_cnt),
        .drop_err (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0][15:0] d;
        logic [7:0][15:0] e;
        logic             sof;
        logic             inv;
        logic [1:0]       gap;
        logic             b2b;
    } vec_t;

    vec_t             tbl [5];
    logic [7:0][15:0] w_outs;
    logic [7:0][15:0] prev;
    logic             prev_inv;
    logic [7:0][15:0] fr_d;
    logic [7:0][15:0] fr_e;
    int               exp_cnt;
    int               last_pulse;
    int               n_checks;
    int               n_err;

    assign w_outs = {out_x7, out_x6, out_x5, out_x4, out_x3, out_x2, out_x1, out_x0};

    function automatic logic [7:0][15:0] pk(int a, int b, int c, int d, int e, int f, int g, int h);
        logic [7:0][15:0] r;
        r[0] = 16'(a); r[1] = 16'(b); r[2] = 16'(c); r[3] = 16'(d);
        r[4] = 16'(e); r[5] = 16'(f); r[6] = 16'(g); r[7] = 16'(h);
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic sof, input logic inv, input logic [15:0] d, input logic clr);
        @(negedge clk);
        in_valid = v;
        in_sof   = sof;
        in_inv   = inv;
        in_data  = d;
        clr_err  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input string name, input logic [7:0][15:0] d, input logic [7:0][15:0] e,
                              input logic sof, input logic inv, input int gap, input logic b2b);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i == 0) && sof, (i == 0) ? inv : ~inv, d[i], 1'b0);
            if (i < 7) begin
                chk({name, " en_low"}, 128'(out_en), 128'(0));
                chk({name, " hold_x"}, w_outs, prev);
                chk({name, " hold_inv"}, 128'(out_inv), 128'(prev_inv));
                for (int g = 0; g < gap; g++) begin
                    step(1'b0, 1'b1, ~inv, 16'hdead, 1'b0);
                    chk({name, " gap_en"}, 128'(out_en), 128'(0));
                end
            end else begin
                exp_cnt = (exp_cnt + 1) % 256;
                chk({name, " en"}, 128'(out_en), 128'(1));
                chk({name, " x"}, w_outs, e);
                chk({name, " inv"}, 128'(out_inv), 128'(inv));
                chk({name, " cnt"}, 128'(frame_cnt), 128'(exp_cnt));
                if (b2b) chk({name, " spacing"}, 128'(cyc - last_pulse), 128'(8));
                last_pulse = cyc;
                prev       = e;
                prev_inv   = inv;
            end
        end
    endtask

    initial begin
        n_checks = 0; n_err = 0; exp_cnt = 0; last_pulse = 0;
        prev = '0; prev_inv = 1'b0;
        reset = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_inv = 1'b0; in_data = '0; clr_err = 1'b0;

        for (int i = 0; i < 8; i++) begin
            tbl[0].d[i] = 16'(i + 1);
            tbl[1].d[i] = 16'(-(i + 1));
            tbl[2].d[i] = 16'(10 * (i + 1));
            tbl[3].d[i] = 16'(i + 1);
            tbl[4].d[i] = 16'(i + 7);
            fr_d[i]     = 16'(i + 1);
        end
        tbl[0].e = pk(1, 5, 3, 7, 2, 6, 4, 8);          tbl[0].sof = 1; tbl[0].inv = 0; tbl[0].gap = 0; tbl[0].b2b = 0;
        tbl[1].e = pk(-1, -5, -3, -7, -2, -6, -4, -8);  tbl[1].sof = 1; tbl[1].inv = 0; tbl[1].gap = 0; tbl[1].b2b = 1;
        tbl[2].e = pk(10, 50, 30, 70, 20, 60, 40, 80);  tbl[2].sof = 1; tbl[2].inv = 1; tbl[2].gap = 0; tbl[2].b2b = 1;
        tbl[3].e = pk(1, 5, 3, 7, 2, 6, 4, 8);          tbl[3].sof = 1; tbl[3].inv = 0; tbl[3].gap = 3; tbl[3].b2b = 0;
        tbl[4].e = pk(7, 11, 9, 13, 8, 12, 10, 14);     tbl[4].sof = 0; tbl[4].inv = 1; tbl[4].gap = 0; tbl[4].b2b = 0;
        fr_e = pk(1, 5, 3, 7, 2, 6, 4, 8);

        repeat (3) @(posedge clk);
        #1;
        chk("rst x", w_outs, '0);
        chk("rst en", 128'(out_en), 128'(0));
        chk("rst inv", 128'(out_inv), 128'(0));
        chk("rst cnt", 128'(frame_cnt), 128'(0));
        chk("rst drop", 128'(drop_err), 128'(0));
        @(negedge clk);
        reset = 1'b1;

        for (int v = 0; v < 5; v++) begin
            send_frame($sformatf("vec%0d", v), tbl[v].d, tbl[v].e, tbl[v].sof, tbl[v].inv, int'(tbl[v].gap), tbl[v].b2b);
        end
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("pulse_width", 128'(out_en), 128'(0));
        chk("no_drop_yet", 128'(drop_err), 128'(0));

        // Partial frame of five samples, then a resync with a new frame.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, i == 0, 1'b0, 16'(i + 1), 1'b0);
            chk("partial en", 128'(out_en), 128'(0));
        end
        chk("partial drop0", 128'(drop_err), 128'(0));
        for (int i = 0; i < 8; i++) fr_d[i] = 16'(100 + i);
        send_frame("resync", fr_d, pk(100, 104, 102, 106, 101, 105, 103, 107), 1'b1, 1'b0, 0, 1'b0);
        chk("drop set", 128'(drop_err), 128'(1));
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("drop clr", 128'(drop_err), 128'(0));

        // Clear and a fresh drop on the same edge: the drop wins.
        step(1'b1, 1'b1, 1'b0, 16'd1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 16'd2, 1'b0);
        step(1'b1, 1'b1, 1'b0, 16'd3, 1'b1);
        chk("drop wins", 128'(drop_err), 128'(1));

        // Asynchronous reset in the middle of a frame (4th sample accepted).
        step(1'b1, 1'b0, 1'b0, 16'd4, 1'b0);
        step(1'b1, 1'b0, 1'b0, 16'd5, 1'b0);
        step(1'b1, 1'b0, 1'b0, 16'd6, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst x", w_outs, '0);
        chk("arst en", 128'(out_en), 128'(0));
        chk("arst inv", 128'(out_inv), 128'(0));
        chk("arst cnt", 128'(frame_cnt), 128'(0));
        chk("arst drop", 128'(drop_err), 128'(0));
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        exp_cnt = 0; prev = '0; prev_inv = 1'b0;
        for (int i = 0; i < 8; i++) fr_d[i] = 16'(i + 1);
        send_frame("post_rst", fr_d, fr_e, 1'b1, 1'b0, 0, 1'b0);
        chk("post_rst drop", 128'(drop_err), 128'(0));

        // 255 more frames: the 256th completion since reset wraps the count.
        for (int f = 0; f < 255; f++) begin
            send_frame("wrap", fr_d, fr_e, 1'b1, 1'b0, 0, 1'b1);
            if (f == 253) chk("cnt 255", 128'(frame_cnt), 128'(255));
        end
        chk("cnt wrap", 128'(frame_cnt), 128'(0));
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("final en", 128'(out_en), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
